// File: rtl/pipeline_sequencer.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Drives stage load enables, stage valids, PC redirect and perf counters.
package pipeline_sequencer_pkg;
  typedef enum logic [1:0] {
    RUN       = 2'd0,
    DMEM_WAIT = 2'd1,
    MD_WAIT   = 2'd2
  } seq_state_t;

  typedef enum logic [3:0] {
    A_BR,
    A_MW,
    A_MD,
    A_LU,
    A_ADV,
    A_HOLD,
    A_MD_STALL,
    A_MD_DRAIN,
    A_MD_EXIT
  } seq_act_t;
endpackage

module pipeline_sequencer
  import pipeline_sequencer_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_valid,
  input  logic             load_use_stop,
  input  logic             took_branch,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             md_start,
  input  logic             md_done,
  output logic             en_IF,
  output logic             en_ID,
  output logic             en_EX,
  output logic             en_MEM,
  output logic             valid_ID,
  output logic             valid_EX,
  output logic             valid_MEM,
  output logic             valid_WB,
  output logic             pc_redirect,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  seq_state_t st_q;
  logic       md_seen_q;
  logic       br;
  logic       mem_stall;
  logic       mw;
  logic       md;
  logic       lu;
  seq_act_t   run_act;
  seq_act_t   act;
  logic [3:0] en_c;
  logic       redir_c;

  assign br        = took_branch & valid_MEM;
  assign mem_stall = dmem_req & valid_MEM & ~dmem_ready;
  assign mw        = mem_stall & ~br;
  assign md        = md_start & valid_EX;
  assign lu        = load_use_stop & valid_ID;

  always_comb begin
    run_act = A_ADV;
    if (br)      run_act = A_BR;
    else if (mw) run_act = A_MW;
    else if (md) run_act = A_MD;
    else if (lu) run_act = A_LU;
  end

  // DMEM_WAIT with ready falls through to the normal RUN decision.
  always_comb begin
    act = run_act;
    unique case (st_q)
      DMEM_WAIT: begin
        if (!dmem_ready) act = A_HOLD;
      end
      MD_WAIT: begin
        if (mem_stall)                 act = A_MD_STALL;
        else if (md_done | md_seen_q) act = A_MD_EXIT;
        else                           act = A_MD_DRAIN;
      end
      default: act = run_act;
    endcase
  end

  always_comb begin
    en_c    = 4'b0000;
    redir_c = 1'b0;
    unique case (act)
      A_BR: begin
        en_c    = 4'b1111;
        redir_c = 1'b1;
      end
      A_MD, A_MD_DRAIN: en_c = 4'b1000;
      A_LU:             en_c = 4'b1100;
      A_ADV, A_MD_EXIT: en_c = 4'b1111;
      default:          en_c = 4'b0000;
    endcase
  end

  assign {en_MEM, en_EX, en_ID, en_IF} = en_c & {4{reset}};
  assign pc_redirect = redir_c & reset;
  assign state       = st_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q      <= RUN;
      md_seen_q <= 1'b0;
      valid_ID  <= 1'b0;
      valid_EX  <= 1'b0;
      valid_MEM <= 1'b0;
      valid_WB  <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!en_c[0] && stall_cnt != CNT_MAX)
        stall_cnt <= stall_cnt + 1'b1;
      unique case (act)
        A_BR: begin
          valid_ID  <= 1'b0;
          valid_EX  <= 1'b0;
          valid_MEM <= 1'b0;
          valid_WB  <= 1'b1;
          st_q      <= RUN;
          if (flush_cnt != CNT_MAX)
            flush_cnt <= flush_cnt + 1'b1;
        end
        A_MW, A_HOLD: begin
          valid_WB <= 1'b0;
          st_q     <= DMEM_WAIT;
        end
        A_MD: begin
          valid_MEM <= 1'b0;
          valid_WB  <= valid_MEM;
          md_seen_q <= 1'b0;
          st_q      <= MD_WAIT;
        end
        A_LU: begin
          valid_EX  <= 1'b0;
          valid_MEM <= valid_EX;
          valid_WB  <= valid_MEM;
          st_q      <= RUN;
        end
        A_ADV: begin
          valid_ID  <= if_valid;
          valid_EX  <= valid_ID;
          valid_MEM <= valid_EX;
          valid_WB  <= valid_MEM;
          st_q      <= RUN;
        end
        A_MD_STALL: begin
          valid_WB  <= 1'b0;
          md_seen_q <= md_seen_q | md_done;
        end
        A_MD_DRAIN: begin
          valid_MEM <= 1'b0;
          valid_WB  <= valid_MEM;
        end
        A_MD_EXIT: begin
          valid_ID  <= if_valid;
          valid_EX  <= valid_ID;
          valid_MEM <= 1'b1;
          valid_WB  <= valid_MEM;
          md_seen_q <= 1'b0;
          st_q      <= RUN;
        end
        default: st_q <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Scoreboard bench for pipeline_sequencer.
// Reference model predictions are queued per cycle and popped at compare time.
module tb_pipeline_sequencer;

  localparam int CW = 3;
  localparam logic [CW-1:0] MAXC = '1;

  typedef struct {
    logic [3:0] en;
    logic       rd;
  } cexp_t;

  typedef struct {
    logic [1:0]    st;
    logic [3:0]    v;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } rexp_t;

  logic          clk;
  logic          reset;
  logic          if_valid;
  logic          load_use_stop;
  logic          took_branch;
  logic          dmem_req;
  logic          dmem_ready;
  logic          md_start;
  logic          md_done;
  logic          en_IF;
  logic          en_ID;
  logic          en_EX;
  logic          en_MEM;
  logic          valid_ID;
  logic          valid_EX;
  logic          valid_MEM;
  logic          valid_WB;
  logic          pc_redirect;
  logic [1:0]    state;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;

  pipeline_sequencer #(.CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .if_valid     (if_valid),
    .load_use_stop(load_use_stop),
    .took_branch  (took_branch),
    .dmem_req     (dmem_req),
    .dmem_ready   (dmem_ready),
    .md_start     (md_start),
    .md_done      (md_done),
    .en_IF        (en_IF),
    .en_ID        (en_ID),
    .en_EX        (en_EX),
    .en_MEM       (en_MEM),
    .valid_ID     (valid_ID),
    .valid_EX     (valid_EX),
    .valid_MEM    (valid_MEM),
    .valid_WB     (valid_WB),
    .pc_redirect  (pc_redirect),
    .state        (state),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_pass;

  cexp_t cq[$];
  rexp_t rq[$];

  logic [1:0]    m_st;
  logic [3:0]    m_v;
  logic          m_seen;
  logic [CW-1:0] m_sc;
  logic [CW-1:0] m_fc;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_st   = 2'd0;
    m_v    = 4'b0000;
    m_seen = 1'b0;
    m_sc   = '0;
    m_fc   = '0;
  endtask

  // m_v bits: {WB, MEM, EX, ID}; en bits: {MEM, EX, ID, IF}
  task automatic model_eval();
    logic       br, stl, md, lu, run;
    logic [3:0] e, nv;
    logic       rd, nseen;
    logic [1:0] ns;
    cexp_t      c;
    rexp_t      r;
    br    = took_branch & m_v[2];
    stl   = dmem_req & m_v[2] & ~dmem_ready;
    md    = md_start & m_v[1];
    lu    = load_use_stop & m_v[0];
    run   = (m_st == 2'd0) || (m_st == 2'd1 && dmem_ready);
    e     = 4'b0000;
    rd    = 1'b0;
    nv    = m_v;
    ns    = m_st;
    nseen = m_seen;
    if (run) begin
      ns = 2'd0;
      if (br) begin
        e = 4'b1111; rd = 1'b1; nv = 4'b1000;
      end else if (stl) begin
        nv[3] = 1'b0; ns = 2'd1;
      end else if (md) begin
        e = 4'b1000; nv = {m_v[2], 1'b0, m_v[1:0]};
        ns = 2'd2; nseen = 1'b0;
      end else if (lu) begin
        e = 4'b1100; nv = {m_v[2:1], 1'b0, m_v[0]};
      end else begin
        e = 4'b1111; nv = {m_v[2:0], if_valid};
      end
    end else if (m_st == 2'd1) begin
      nv[3] = 1'b0;
    end else if (stl) begin
      nv[3] = 1'b0; nseen = m_seen | md_done;
    end else if (md_done | m_seen) begin
      e = 4'b1111; nv = {m_v[2], 1'b1, m_v[0], if_valid};
      ns = 2'd0; nseen = 1'b0;
    end else begin
      e = 4'b1000; nv = {m_v[2], 1'b0, m_v[1:0]};
    end
    if (!e[0] && m_sc != MAXC) m_sc = m_sc + 1'b1;
    if (run && br && m_fc != MAXC) m_fc = m_fc + 1'b1;
    m_st   = ns;
    m_v    = nv;
    m_seen = nseen;
    c.en = e;
    c.rd = rd;
    cq.push_back(c);
    r.st = m_st;
    r.v  = m_v;
    r.sc = m_sc;
    r.fc = m_fc;
    rq.push_back(r);
  endtask

  // Called just after a negedge with inputs already applied.
  task automatic step();
    cexp_t c;
    rexp_t r;
    model_eval();
    #1;
    c = cq.pop_front();
    chk("en", 32'({en_MEM, en_EX, en_ID, en_IF}), 32'(c.en));
    chk("pc_redirect", 32'(pc_redirect), 32'(c.rd));
    @(posedge clk);
    #1;
    r = rq.pop_front();
    chk("state", 32'(state), 32'(r.st));
    chk("valid", 32'({valid_WB, valid_MEM, valid_EX, valid_ID}), 32'(r.v));
    chk("stall_cnt", 32'(stall_cnt), 32'(r.sc));
    chk("flush_cnt", 32'(flush_cnt), 32'(r.fc));
    @(negedge clk);
  endtask

  task automatic clr_inputs();
    if_valid      = 1'b0;
    load_use_stop = 1'b0;
    took_branch   = 1'b0;
    dmem_req      = 1'b0;
    dmem_ready    = 1'b0;
    md_start      = 1'b0;
    md_done       = 1'b0;
  endtask

  initial begin
    int n2;
    n_chk  = 0;
    n_pass = 0;
    reset  = 1'b0;
    clr_inputs();
    model_reset();
    #3;
    chk("rst_state", 32'(state), 32'(0));
    chk("rst_valid", 32'({valid_WB, valid_MEM, valid_EX, valid_ID}), 32'(0));
    chk("rst_en", 32'({en_MEM, en_EX, en_ID, en_IF}), 32'(0));
    chk("rst_redirect", 32'(pc_redirect), 32'(0));
    chk("rst_stall", 32'(stall_cnt), 32'(0));
    chk("rst_flush", 32'(flush_cnt), 32'(0));
    @(negedge clk);
    reset = 1'b1;

    // straight line
    if_valid = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("line_wb", 32'(valid_WB), 32'(1));
    step();
    chk("line_stall", 32'(stall_cnt), 32'(0));

    // load-use bubble
    load_use_stop = 1'b1;
    #1;
    chk("lu_en", 32'({en_MEM, en_EX, en_ID, en_IF}), 32'(4'b1100));
    step();
    load_use_stop = 1'b0;
    chk("lu_vex", 32'(valid_EX), 32'(0));
    chk("lu_stall", 32'(stall_cnt), 32'(1));

    // branch beats load-use and mul/div
    took_branch   = 1'b1;
    load_use_stop = 1'b1;
    md_start      = 1'b1;
    #1;
    chk("br_redirect", 32'(pc_redirect), 32'(1));
    step();
    clr_inputs();
    chk("br_valid", 32'({valid_WB, valid_MEM, valid_EX, valid_ID}), 32'(4'b1000));
    chk("br_flush", 32'(flush_cnt), 32'(1));
    chk("br_state", 32'(state), 32'(0));

    // data-memory wait
    if_valid = 1'b1;
    for (int i = 0; i < 3; i++) step();
    dmem_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("dw_en", 32'({en_MEM, en_EX, en_ID, en_IF}), 32'(0));
      step();
      chk("dw_state", 32'(state), 32'(1));
      chk("dw_wb", 32'(valid_WB), 32'(0));
    end
    dmem_ready = 1'b1;
    step();
    dmem_req   = 1'b0;
    dmem_ready = 1'b0;
    chk("dw_exit_state", 32'(state), 32'(0));
    chk("dw_stall", 32'(stall_cnt), 32'(4));

    // mul/div, done on the fifth wait cycle
    n2 = 0;
    md_start = 1'b1;
    step();
    md_start = 1'b0;
    if (state == 2'd2) n2++;
    for (int i = 0; i < 4; i++) begin
      step();
      if (state == 2'd2) n2++;
    end
    md_done = 1'b1;
    step();
    md_done = 1'b0;
    chk("md_wait_cycles", 32'(n2), 32'(5));
    chk("md_exit_state", 32'(state), 32'(0));
    chk("md_vmem", 32'(valid_MEM), 32'(1));
    chk("md_stall_sat", 32'(stall_cnt), 32'(MAXC));

    // mul/div with dmem pending, reset mid-wait
    step();
    md_start = 1'b1;
    step();
    md_start = 1'b0;
    dmem_req = 1'b1;
    step();
    step();
    chk("md2_state", 32'(state), 32'(2));
    #2;
    reset = 1'b0;
    #1;
    chk("arst_state", 32'(state), 32'(0));
    chk("arst_valid", 32'({valid_WB, valid_MEM, valid_EX, valid_ID}), 32'(0));
    chk("arst_en", 32'({en_MEM, en_EX, en_ID, en_IF}), 32'(0));
    chk("arst_redirect", 32'(pc_redirect), 32'(0));
    chk("arst_stall", 32'(stall_cnt), 32'(0));
    @(posedge clk);
    #1;
    chk("arst_hold", 32'(state), 32'(0));
    @(negedge clk);
    reset = 1'b1;
    clr_inputs();
    model_reset();

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      if_valid      = ($urandom_range(3) != 0);
      load_use_stop = ($urandom_range(4) == 0);
      took_branch   = ($urandom_range(9) == 0);
      dmem_req      = ($urandom_range(2) == 0);
      dmem_ready    = ($urandom_range(1) == 0);
      md_start      = ($urandom_range(6) == 0);
      md_done       = ($urandom_range(4) == 0);
      step();
    end
    clr_inputs();

    chk("sb_empty", 32'(cq.size() + rq.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
